pipeline_adder_arbiter: RTL and testbench

PIPELINE_ADDER_ARBITER -- requirements
Module: pipeline_adder_arbiter

---
 rtl/pipeline_adder_arbiter_pkg.sv | 13 +
 rtl/pipeline_rc_adder.sv | 39 +++
 rtl/pipeline_adder_arbiter.sv | 103 ++++++++++
 tb/tb_pipeline_adder_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_adder_arbiter_pkg.sv
// Shared constants for the arbitrated pipelined adder: latencies and the
// requester-index width helper.
package pipeline_adder_arbiter_pkg;

  localparam int ADD_LAT   = 2;
  localparam int TOTAL_LAT = ADD_LAT + 1;

  // A requester index needs at least one bit even for two requesters.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_rc_adder.sv
// Two-stage ripple-carry adder: the low half resolves in the first stage, the
// high half plus the registered mid carry in the second. Datapath only, no reset.
module pipeline_rc_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic [LO_W:0]   lo_p1;
  logic [HI_W-1:0] a_hi_p1;
  logic [HI_W-1:0] b_hi_p1;
  logic [LO_W-1:0] lo_p2;
  logic [HI_W:0]   hi_p2;

  // stage 1: low half, high operands carried along
  always_ff @(posedge clk) begin
    lo_p1   <= {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
    a_hi_p1 <= a[WIDTH-1:LO_W];
    b_hi_p1 <= b[WIDTH-1:LO_W];
  end

  // stage 2: high half consumes the low-half carry
  always_ff @(posedge clk) begin
    lo_p2 <= lo_p1[LO_W-1:0];
    hi_p2 <= {1'b0, a_hi_p1} + {1'b0, b_hi_p1} + {{HI_W{1'b0}}, lo_p1[LO_W]};
  end

  assign sum  = {hi_p2[HI_W-1:0], lo_p2};
  assign cout = hi_p2[HI_W];

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Round-robin arbiter in front of one shared two-stage adder; results come back
// in acceptance order with a fixed latency, tagged with the requester index.
module pipeline_adder_arbiter
  import pipeline_adder_arbiter_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int NREQ  = 4,
  localparam int IDW   = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [1:0]            inflight
);

  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       gid;
  logic [NREQ-1:0]      grant;
  logic                 accept;
  logic [WIDTH-1:0]     a_p0;
  logic [WIDTH-1:0]     b_p0;
  logic                 cin_p0;
  logic [TOTAL_LAT-1:0] vld_sr;
  logic [IDW-1:0]       id_sr [TOTAL_LAT];

  // First valid requester at or above the pointer, wrapping past NREQ-1.
  always_comb begin
    int             j;
    logic           found;
    logic [IDW-1:0] idx;
    grant = '0;
    gid   = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = IDW'(j);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

  assign req_ready = rst ? '0 : grant;
  assign accept    = |(req_valid & req_ready);

  // issue register: operands of the winner, captured only on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= req_a[int'(gid)*WIDTH +: WIDTH];
      b_p0   <= req_b[int'(gid)*WIDTH +: WIDTH];
      cin_p0 <= req_cin[gid];
    end
  end

  pipeline_rc_adder #(.WIDTH(WIDTH)) u_adder (
    .clk  (clk),
    .a    (a_p0),
    .b    (b_p0),
    .cin  (cin_p0),
    .sum  (rsp_sum),
    .cout (rsp_cout)
  );

  // Control state: pointer, valid shift register and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      vld_sr   <= '0;
      inflight <= 2'd0;
    end else begin
      if (accept) ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
      vld_sr <= {vld_sr[TOTAL_LAT-2:0], accept};
      case ({accept, rsp_valid})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Requester index rides alongside the adder stages; masked by vld_sr.
  always_ff @(posedge clk) begin
    id_sr[0] <= gid;
    for (int k = 1; k < TOTAL_LAT; k++) id_sr[k] <= id_sr[k-1];
  end

  assign rsp_valid = vld_sr[TOTAL_LAT-1];
  assign rsp_id    = id_sr[TOTAL_LAT-1];

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Directed and scoreboarded bench for pipeline_adder_arbiter (WIDTH=64, NREQ=4).
module tb_pipeline_adder_arbiter;

  localparam int W = 64;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     inflight;

  pipeline_adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [63:0] sum;
    logic        cout;
  } exp_t;

  vec_t vt [7];
  exp_t q [$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic set_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic c);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = c;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return one << ((p + k) % N);
    end
    return 4'b0000;
  endfunction

  logic [63:0] ca [N];
  logic [63:0] cb [N];
  logic        cc [N];

  initial begin
    logic [3:0]  eg;
    logic [64:0] full;
    logic        erv;
    int          mptr;
    int          gi;
    int          acc;
    int          dec;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;

    vt[0] = '{2, 64'd5, 64'd7, 1'b1, 64'd13, 1'b0};
    vt[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
    vt[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vt[3] = '{3, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
    vt[4] = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    vt[5] = '{1, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 64'h0000_0001_0000_0000, 1'b0};
    vt[6] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};

    // Reset state with every requester asking
    repeat (2) @(posedge clk);
    #1; req_valid = '1; #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_inflight", inflight, 0);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-request vectors: accept, then result three cycles later
    foreach (vt[v]) begin
      set_op(vt[v].id, vt[v].a, vt[v].b, vt[v].cin);
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", v), req_ready, 64'd1 << vt[v].id);
      @(posedge clk); #1;
      req_valid = '0;
      chk($sformatf("v%0d_early1", v), rsp_valid, 0);
      chk($sformatf("v%0d_inflight1", v), inflight, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_early2", v), rsp_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", v), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_id", v), rsp_id, vt[v].id);
      chk($sformatf("v%0d_rsp_sum", v), rsp_sum, vt[v].sum);
      chk($sformatf("v%0d_rsp_cout", v), rsp_cout, vt[v].cout);
      chk($sformatf("v%0d_inflight2", v), inflight, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_after", v), rsp_valid, 0);
      chk($sformatf("v%0d_inflight0", v), inflight, 0);
    end

    // All four requesters continuously valid for eight cycles
    do_reset();
    for (int i = 0; i < N; i++) begin
      ca[i] = 64'hF000_0000_0000_0000 + 64'(i);
      cb[i] = 64'h1000_0000_0000_0000 * 64'(i + 1);
      cc[i] = i[0];
      set_op(i, ca[i], cb[i], cc[i]);
    end
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) chk($sformatf("rr4_ready_c%0d", c), req_ready, 64'd1 << (c % N));
      acc = (c < 8) ? c : 8;
      dec = (c - 3 < 0) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
      chk($sformatf("rr4_inflight_c%0d", c), inflight, acc - dec);
      chk($sformatf("rr4_rsp_valid_c%0d", c), rsp_valid, (c >= 3 && c < 11));
      if (c >= 3 && c < 11) begin
        gi   = (c - 3) % N;
        full = {1'b0, ca[gi]} + {1'b0, cb[gi]} + 65'(cc[gi]);
        chk($sformatf("rr4_rsp_id_c%0d", c), rsp_id, gi);
        chk($sformatf("rr4_rsp_sum_c%0d", c), rsp_sum, full[63:0]);
        chk($sformatf("rr4_rsp_cout_c%0d", c), rsp_cout, full[64]);
      end
      @(posedge clk); #1;
    end

    // Only requesters 1 and 3 valid: grants alternate between them
    do_reset();
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("alt_ready_c%0d", c), req_ready, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      if (c >= 3) chk($sformatf("alt_rsp_id_c%0d", c), rsp_id, (c % 2 == 1) ? 1 : 3);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Two acceptances, then reset pulsed while both are in flight
    do_reset();
    req_valid = 4'b0011;
    #1;
    chk("mid_ready0", req_ready, 4'b0001);
    @(posedge clk); #1;
    chk("mid_ready1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("mid_no_rsp_c%0d", c), rsp_valid, 0);
      chk($sformatf("mid_inflight_c%0d", c), inflight, 0);
      @(posedge clk); #1;
    end
    req_valid = 4'b0110;
    #1;
    chk("mid_ptr_zero", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic against a reference arbiter and an in-order scoreboard
    do_reset();
    q.delete();
    mptr = 0;
    for (int c = 0; c < 1004; c++) begin
      if (c < 1000) begin
        req_valid = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) begin
          set_op(i, ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
      end else begin
        req_valid = '0;
      end
      #1;
      eg = rr_pick(req_valid, mptr);
      chk($sformatf("rnd_ready_c%0d", c), req_ready, eg);
      chk($sformatf("rnd_inflight_c%0d", c), inflight, q.size());
      erv = (q.size() > 0) && (q[0].due == c);
      chk($sformatf("rnd_rsp_valid_c%0d", c), rsp_valid, erv);
      if (erv) begin
        if (rsp_valid) begin
          chk($sformatf("rnd_rsp_id_c%0d", c), rsp_id, q[0].id);
          chk($sformatf("rnd_rsp_sum_c%0d", c), rsp_sum, q[0].sum);
          chk($sformatf("rnd_rsp_cout_c%0d", c), rsp_cout, q[0].cout);
        end
        void'(q.pop_front());
      end
      if (eg != 4'b0000) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (eg[i]) gi = i;
        full = {1'b0, req_a[gi*W +: W]} + {1'b0, req_b[gi*W +: W]} + 65'(req_cin[gi]);
        q.push_back('{c + 3, gi, full[63:0], full[64]});
        mptr = (gi + 1) % N;
      end
      @(posedge clk); #1;
    end
    chk("rnd_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
